// File: rtl/mandelbrot_pkg.sv
// Shared constants for the Mandelbrot framebuffer writer.
// FSM encoding and default frame/timeout sizes.
package mandelbrot_pkg;

    localparam int PIX_W           = 4;
    localparam int DEF_NUM_PIXELS  = 76800;
    localparam int DEF_ACK_TIMEOUT = 255;
    localparam int DEF_EXIT_CYCLES = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTER    = 3'd1;
    localparam logic [2:0] S_WAIT_PIX = 3'd2;
    localparam logic [2:0] S_STROBE   = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_EXIT     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_ERROR    = 3'd7;

endpackage

// File: rtl/mandelbrot_fb_writer_if.sv
// Control, pixel stream and framebuffer signals of the writer.
// master = writer side, slave = environment side.
interface mandelbrot_fb_writer_if;
    import mandelbrot_pkg::*;

    logic             start;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             write_mode;
    logic             reset_write_ptr;
    logic [PIX_W-1:0] write_data_in;
    logic             write_data;
    logic             wrote_data;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start, pix_valid, pix_data, wrote_data,
        output pix_ready, write_mode, reset_write_ptr,
        output write_data_in, write_data, busy, done, error
    );

    modport slave (
        output start, pix_valid, pix_data, wrote_data,
        input  pix_ready, write_mode, reset_write_ptr,
        input  write_data_in, write_data, busy, done, error
    );

endinterface

// File: rtl/mandelbrot_fb_writer_timer.sv
// Acknowledge watchdog: counts enabled cycles, cleared on state change.
// expired flags the last allowed cycle so the FSM leaves on the next edge.
module fb_ack_timer
    import mandelbrot_pkg::*;
#(
    parameter int TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mandelbrot_fb_writer.sv
// Streams one frame of pixels into the framebuffer with per-pixel ack.
// Outputs are registered from the next state so they align with state.
module mandelbrot_fb_writer
    import mandelbrot_pkg::*;
#(
    parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int EXIT_CYCLES = DEF_EXIT_CYCLES
) (
    input logic clk,
    input logic rst_n,
    mandelbrot_fb_writer_if.master bus
);

    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam int EW = $clog2(EXIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_PIX  = CW'(NUM_PIXELS - 1);
    localparam logic [EW-1:0] LAST_EXIT = EW'(EXIT_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] pix_cnt;
    logic [EW-1:0] exit_cnt;
    logic          expired;
    logic          tmr_en;
    logic          tmr_clr;
    logic          hs;
    logic          rearm;
    logic          acked;

    assign hs     = bus.pix_valid && bus.pix_ready;
    assign acked  = (state == S_ACK) && bus.wrote_data;
    assign rearm  = bus.start && (state == S_IDLE ||
                    state == S_DONE || state == S_ERROR);
    assign tmr_en  = (state == S_ENTER) || (state == S_ACK);
    assign tmr_clr = (state_nx != state);

    fb_ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tmr_en),
        .clear   (tmr_clr),
        .expired (expired)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (bus.start) state_nx = S_ENTER;
            S_ENTER: begin
                if (bus.wrote_data) state_nx = S_WAIT_PIX;
                else if (expired)   state_nx = S_ERROR;
            end
            S_WAIT_PIX: if (hs) state_nx = S_STROBE;
            S_STROBE:   state_nx = S_ACK;
            S_ACK: begin
                if (bus.wrote_data)
                    state_nx = (pix_cnt == LAST_PIX) ? S_EXIT : S_WAIT_PIX;
                else if (expired)
                    state_nx = S_ERROR;
            end
            S_EXIT:     if (exit_cnt == LAST_EXIT) state_nx = S_DONE;
            S_DONE:     state_nx = bus.start ? S_ENTER : S_IDLE;
            S_ERROR:    if (bus.start) state_nx = S_ENTER;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            pix_cnt             <= '0;
            exit_cnt            <= '0;
            bus.write_mode      <= 1'b0;
            bus.reset_write_ptr <= 1'b0;
            bus.write_data      <= 1'b0;
            bus.write_data_in   <= '0;
            bus.pix_ready       <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.error           <= 1'b0;
        end else begin
            state <= state_nx;
            if (rearm)      pix_cnt <= '0;
            else if (acked) pix_cnt <= pix_cnt + CW'(1);
            exit_cnt <= (state == S_EXIT) ? exit_cnt + EW'(1) : '0;
            if (state == S_WAIT_PIX && hs)
                bus.write_data_in <= bus.pix_data;
            bus.write_mode <= (state_nx == S_ENTER) ||
                              (state_nx == S_WAIT_PIX) ||
                              (state_nx == S_STROBE) ||
                              (state_nx == S_ACK);
            bus.reset_write_ptr <= (state_nx == S_ENTER);
            bus.write_data      <= (state_nx == S_STROBE);
            bus.pix_ready       <= (state_nx == S_WAIT_PIX);
            bus.busy  <= !(state_nx == S_IDLE || state_nx == S_DONE ||
                           state_nx == S_ERROR);
            bus.done  <= (state_nx == S_DONE);
            // ERROR is only left through start, so this is sticky until then
            bus.error <= (state_nx == S_ERROR);
        end
    end

endmodule

// File: tb/tb_mandelbrot_fb_writer.sv
// Directed bench: a 4-pixel frame unit and a short-timeout unit,
// each driven by a small framebuffer model.
module tb_mandelbrot_fb_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mandelbrot_fb_writer_if u0 ();
    mandelbrot_fb_writer_if u1 ();

    mandelbrot_fb_writer #(
        .NUM_PIXELS(4), .ACK_TIMEOUT(255), .EXIT_CYCLES(4)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(u0.master));

    mandelbrot_fb_writer #(
        .NUM_PIXELS(4), .ACK_TIMEOUT(10), .EXIT_CYCLES(4)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(u1.master));

    logic ack0 = 1'b0;
    logic ack1 = 1'b0;
    logic spur0 = 1'b0;
    logic stall0 = 1'b0;
    assign u0.wrote_data = ack0 | spur0;
    assign u1.wrote_data = ack1;

    int   age0 = 0, sd0 = 0, idx0 = 0, dn0 = 0, dcyc = 0;
    int   rwp_hi = 0, rwp_bad = 0;
    logic rdy0 = 1'b0;
    logic [3:0] wq[$];
    int   scyc[$];
    int   age1 = 0;

    // Unit 0 framebuffer: ack 16 cycles into ENTER, 2 cycles after strobe
    always @(posedge clk) begin
        #1;
        ack0 = 1'b0;
        if (u0.reset_write_ptr && u0.write_mode) begin
            age0++;
            if (age0 == 16) ack0 = 1'b1;
        end else begin
            age0 = 0;
        end
        if (sd0 > 0) begin
            sd0--;
            if (sd0 == 0) ack0 = 1'b1;
        end
        if (u0.write_data) begin
            sd0 = 2;
            wq.push_back(u0.write_data_in);
            scyc.push_back(cyc);
            if (u0.reset_write_ptr) rwp_bad++;
        end
        if (u0.done) begin
            dn0++;
            dcyc = cyc;
        end
        if (u0.reset_write_ptr) rwp_hi++;
        if (u0.reset_write_ptr) idx0 = 0;
        else if (rdy0 && u0.pix_valid) idx0++;
        rdy0 = u0.pix_ready;
        u0.pix_valid = !stall0 && idx0 < 4;
        u0.pix_data = 4'(idx0 + 1);
    end

    // Unit 1 framebuffer: acks ENTER after 3 cycles, never acks strobes
    always @(posedge clk) begin
        #1;
        ack1 = 1'b0;
        if (u1.reset_write_ptr) begin
            age1++;
            if (age1 == 3) ack1 = 1'b1;
        end else begin
            age1 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        u0.start = 1'b0;
        u1.start = 1'b0;
        u1.pix_valid = 1'b1;
        u1.pix_data = 4'd9;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({u0.write_mode, u0.reset_write_ptr, u0.write_data,
             u0.pix_ready, u0.busy, u0.done, u0.error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl0 got %b want 0",
                     {u0.write_mode, u0.reset_write_ptr, u0.write_data,
                      u0.pix_ready, u0.busy, u0.done, u0.error});
        end
        checks++;
        if (u0.write_data_in !== 4'd0) begin
            errors++;
            $display("FAIL reset_wdi got %0d want 0", u0.write_data_in);
        end
        checks++;
        if ({u1.write_mode, u1.busy, u1.error} !== 3'b0) begin
            errors++;
            $display("FAIL reset_ctl1 got %b want 0",
                     {u1.write_mode, u1.busy, u1.error});
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_frame();
        int wb, db, rb, hb, n;
        wb = wq.size();
        db = dn0;
        rb = rwp_bad;
        hb = rwp_hi;
        u0.start = 1'b1;
        tick();
        u0.start = 1'b0;
        checks++;
        if ({u0.reset_write_ptr, u0.write_mode, u0.busy} !== 3'b111) begin
            errors++;
            $display("FAIL frame_enter got %b want 111",
                     {u0.reset_write_ptr, u0.write_mode, u0.busy});
        end
        n = 0;
        while (dn0 == db && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (dn0 == db) begin
            errors++;
            $display("FAIL frame_done_timeout got none want done");
        end
        repeat (3) tick();
        checks++;
        if (wq.size() - wb !== 4) begin
            errors++;
            $display("FAIL frame_strobes got %0d want 4", wq.size() - wb);
        end
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wq.size()) begin
                checks++;
                if (wq[wb + i] !== 4'(i + 1)) begin
                    errors++;
                    $display("FAIL frame_pix%0d got %0d want %0d",
                             i, wq[wb + i], i + 1);
                end
            end
        end
        checks++;
        if (dn0 - db !== 1) begin
            errors++;
            $display("FAIL frame_done_count got %0d want 1", dn0 - db);
        end
        checks++;
        if (rwp_hi - hb !== 16) begin
            errors++;
            $display("FAIL frame_rwp_cycles got %0d want 16", rwp_hi - hb);
        end
        checks++;
        if (rwp_bad - rb !== 0) begin
            errors++;
            $display("FAIL frame_rwp_strobe got %0d want 0", rwp_bad - rb);
        end
        if (scyc.size() >= wb + 4) begin
            checks++;
            if (scyc[wb + 1] - scyc[wb] !== 4) begin
                errors++;
                $display("FAIL frame_rate got %0d want 4",
                         scyc[wb + 1] - scyc[wb]);
            end
            checks++;
            if (dcyc - scyc[wb + 3] !== 7) begin
                errors++;
                $display("FAIL frame_exit got %0d want 7",
                         dcyc - scyc[wb + 3]);
            end
        end
        checks++;
        if ({u0.write_mode, u0.busy, u0.done, u0.error} !== 4'b0) begin
            errors++;
            $display("FAIL frame_idle got %b want 0",
                     {u0.write_mode, u0.busy, u0.done, u0.error});
        end
    endtask

    task automatic test_stall_spurious();
        int wb, bad, n;
        stall0 = 1'b1;
        repeat (2) tick();
        wb = wq.size();
        u0.start = 1'b1;
        tick();
        u0.start = 1'b0;
        n = 0;
        while (!u0.pix_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (u0.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready got %b want 1", u0.pix_ready);
        end
        bad = 0;
        repeat (50) begin
            tick();
            if (u0.write_data || !u0.write_mode || u0.error ||
                !u0.pix_ready) bad++;
        end
        checks++;
        if (bad !== 0 || wq.size() !== wb) begin
            errors++;
            $display("FAIL stall_hold got %0d bad %0d strobes want 0 0",
                     bad, wq.size() - wb);
        end
        spur0 = 1'b1;
        tick();
        spur0 = 1'b0;
        u0.start = 1'b1;
        tick();
        u0.start = 1'b0;
        tick();
        checks++;
        if ({u0.pix_ready, u0.write_mode, u0.reset_write_ptr} !== 3'b110) begin
            errors++;
            $display("FAIL spurious_ignored got %b want 110",
                     {u0.pix_ready, u0.write_mode, u0.reset_write_ptr});
        end
        stall0 = 1'b0;
    endtask

    task automatic test_done_restart();
        int wb, db, n;
        wb = wq.size();
        db = dn0;
        n = 0;
        while (dn0 == db && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (wq.size() - wb !== 4) begin
            errors++;
            $display("FAIL spurious_count got %0d want 4", wq.size() - wb);
        end
        u0.start = 1'b1;
        tick();
        u0.start = 1'b0;
        checks++;
        if ({u0.reset_write_ptr, u0.busy, u0.done} !== 3'b110) begin
            errors++;
            $display("FAIL restart_on_done got %b want 110",
                     {u0.reset_write_ptr, u0.busy, u0.done});
        end
    endtask

    task automatic test_reset_mid();
        int wb, db, n;
        wb = wq.size();
        db = dn0;
        n = 0;
        while (wq.size() - wb < 2 && n < 200) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({u0.write_mode, u0.reset_write_ptr, u0.write_data,
             u0.pix_ready, u0.busy, u0.done, u0.error} !== 7'b0 ||
            u0.write_data_in !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got %b/%0d want 0/0",
                     {u0.write_mode, u0.reset_write_ptr, u0.write_data,
                      u0.pix_ready, u0.busy, u0.done, u0.error},
                     u0.write_data_in);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (dn0 !== db || u0.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done got %0d busy %b want 0 0",
                     dn0 - db, u0.busy);
        end
    endtask

    task automatic test_timeout();
        int s, e, n;
        s = -1;
        e = -1;
        u1.start = 1'b1;
        tick();
        u1.start = 1'b0;
        n = 0;
        while (e < 0 && n < 100) begin
            if (u1.write_data && s < 0) begin
                s = cyc;
                checks++;
                if (u1.write_data_in !== 4'd9) begin
                    errors++;
                    $display("FAIL timeout_data got %0d want 9",
                             u1.write_data_in);
                end
            end
            if (u1.error) e = cyc;
            if (e < 0) tick();
            n++;
        end
        checks++;
        if (s < 0 || e - s !== 11) begin
            errors++;
            $display("FAIL timeout_delay got %0d want 11", e - s);
        end
        repeat (5) tick();
        checks++;
        if ({u1.error, u1.write_mode, u1.busy} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_state got %b want 100",
                     {u1.error, u1.write_mode, u1.busy});
        end
        u1.start = 1'b1;
        tick();
        u1.start = 1'b0;
        checks++;
        if ({u1.error, u1.write_mode, u1.reset_write_ptr} !== 3'b011) begin
            errors++;
            $display("FAIL timeout_clear got %b want 011",
                     {u1.error, u1.write_mode, u1.reset_write_ptr});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall_spurious();
        test_done_restart();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandelbrot_fb_writer.md
MANDELBROT_FB_WRITER -- requirements
Module: mandelbrot_fb_writer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 76800, meaning pixels written per frame (320x240).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning max cycles to wait for wrote_data.
REQ-003 SHALL have parameter EXIT_CYCLES, default 4, meaning cycles write_mode is held low after a frame before done.
REQ-004 clk  in  1  sole clock, rising edge; one clock, all logic in this domain.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse; begins a frame write (ignored unless IDLE, DONE or ERROR).
REQ-007 pix_valid  in  1  upstream pixel valid.
REQ-008 pix_data  in  4  gray value (iteration count) of current pixel.
REQ-009 pix_ready  out  1  pixel accepted when pix_valid and pix_ready both high on a rising edge.
REQ-010 write_mode  out  1  to framebuffer; high for the whole frame write.
REQ-011 reset_write_ptr  out  1  to framebuffer; rewinds RAM write pointer.
REQ-012 write_data_in  out  4  to framebuffer; pixel value.
REQ-013 write_data  out  1  to framebuffer; one-cycle write strobe.
REQ-014 wrote_data  in  1  from framebuffer; one-cycle acknowledge pulse.
REQ-015 busy  out  1  high in every state except IDLE, DONE, ERROR.
REQ-016 done  out  1  one-cycle pulse on frame completion.
REQ-017 error  out  1  sticky timeout flag, cleared by start or reset.

Function
REQ-018 FSM states SHALL be IDLE, ENTER, WAIT_PIX, STROBE, ACK, EXIT, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start SHALL go to ENTER, clear pixel counter, error and timeout counter.
REQ-020 ENTER SHALL drive write_mode=1, reset_write_ptr=1; on wrote_data go to WAIT_PIX with reset_write_ptr=0 from the next cycle.
REQ-021 WAIT_PIX SHALL drive pix_ready=1 (only state with pix_ready=1); on handshake register pix_data into write_data_in and go to STROBE.
REQ-022 STROBE SHALL drive write_data=1 for exactly one cycle, then go to ACK.
REQ-023 ACK SHALL hold write_data_in stable; on wrote_data increment pixel counter; go to EXIT if counter reaches NUM_PIXELS, else WAIT_PIX.
REQ-024 wrote_data outside ENTER and ACK SHALL be ignored.
REQ-025 Timeout counter SHALL count cycles in ENTER and ACK, clear on every state change; reaching ACK_TIMEOUT SHALL go to ERROR.
REQ-026 ERROR SHALL drive write_mode=0, set error=1, leave pixel counter frozen.
REQ-027 EXIT SHALL drive write_mode=0 for EXIT_CYCLES cycles, then go to DONE with done=1 for one cycle; DONE returns to IDLE next cycle unless start.
REQ-028 write_mode SHALL be 1 exactly in ENTER, WAIT_PIX, STROBE, ACK.
REQ-029 start while busy SHALL be ignored; start in same cycle as done SHALL begin a new frame.
REQ-030 Pixel counter width SHALL be $clog2(NUM_PIXELS+1); counter SHALL never exceed NUM_PIXELS.
REQ-031 Minimum throughput SHALL be one pixel per 4 cycles (WAIT_PIX, STROBE, 2-cycle framebuffer ack); all outputs registered.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, write_mode=0, reset_write_ptr=0, write_data=0, write_data_in=0, pix_ready=0, busy=0, done=0, error=0, counters=0.
REQ-033 Reset mid-frame SHALL abandon the frame; no partial-frame completion or done pulse.

Structure
REQ-034 State encoding and default NUM_PIXELS/ACK_TIMEOUT SHALL live in shared package mandelbrot_pkg.
REQ-035 Timeout counter MAY be sub-module fb_ack_timer (enable, clear, expired); everything else in one module.

Verification
REQ-036 NUM_PIXELS=4, framebuffer model acking 16 cycles after write_mode then 2 cycles after each strobe, pixels 1,2,3,4 -> four write_data pulses carrying 1,2,3,4, done once, write_mode low afterward.
REQ-037 start -> reset_write_ptr=1 until first wrote_data, then 0 for all subsequent strobes.
REQ-038 No ack after strobe with ACK_TIMEOUT=10 -> ERROR after 10 cycles, error=1, write_mode=0; next start clears error.
REQ-039 pix_valid low 50 cycles in WAIT_PIX -> no strobe, write_mode stays 1, no timeout.
REQ-040 rst_n low during ACK of pixel 2 -> all outputs reset values immediately; no done.
REQ-041 Spurious wrote_data in WAIT_PIX -> counter unchanged, no state change.
